trig_acq_ctrl: RTL and testbench

Acquisition trigger controller for the 200 MHz DSO capture path. It arms capture after a programmable pre-trigger depth and qualifies raw trigger edges against the holdoff busy flag. On a qualified trigger it issues the trigger-after pulse and reloads holdoff timing downstream, then counts the post-trigger depth and reports completion. It drives the capture-memory write enable and address, and latches the trigger address.

---
 rtl/trig_acq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_trig_acq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trig_acq_ctrl.sv
// rtl/trig_acq_ctrl.sv - DSO acquisition trigger controller; auto-trigger timer enabled by TRIG_AUTO_EN
module trig_acq_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 32
) (
    input  logic               clk_200M,
    input  logic               rst_n,
    input  logic               acq_start,
    input  logic               acq_stop,
    input  logic               trig_raw,
    input  logic               force_trig,
    input  logic               holdoff_busy,
    input  logic [DEPTH_W-1:0] pre_depth,
    input  logic [DEPTH_W-1:0] post_depth,
    input  logic [31:0]        auto_timeout,
    output logic               trig_aft_pul,
    output logic               trig_holdoff_reload,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ADDR_W-1:0]  trig_addr,
    output logic [2:0]         acq_state,
    output logic               acq_done,
    output logic               trig_auto
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q;
    logic               sync1_q, sync2_q, sync3_q;
    logic [DEPTH_W-1:0] cnt_q, depth_q;
    logic               wr_en_q, acq_done_q;
    logic [ADDR_W-1:0]  wr_addr_q, trig_addr_q;
    logic [1:0]         aft_cnt_q, rld_cnt_q;
    logic               aft_q, rld_n_q;

    logic               trig_edge, qual_trig, auto_hit;
    logic               start_ok, fire, cnt_last;

    // Edge is only seen after two metastability flops; the third flop holds history.
    assign trig_edge = sync2_q & ~sync3_q;
    assign qual_trig = (trig_edge & ~holdoff_busy) | force_trig;
    assign start_ok  = (state_q == S_IDLE) & acq_start & ~acq_stop;
    assign fire      = (state_q == S_ARMED) & ~acq_stop & (qual_trig | auto_hit);
    assign cnt_last  = (cnt_q == depth_q - DEPTH_W'(1));

`ifdef TRIG_AUTO_EN
    logic [31:0] timer_q;
    logic        trig_auto_q;

    assign auto_hit  = (auto_timeout != 32'd0) && (timer_q == auto_timeout - 32'd1);
    assign trig_auto = trig_auto_q;

    // Count cycles spent in ARMED; restarts from zero on every ARMED entry.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= 32'd0;
        end else if (state_q == S_ARMED) begin
            timer_q <= timer_q + 32'd1;
        end else begin
            timer_q <= 32'd0;
        end
    end

    // Remember whether the last trigger was produced by the timer rather than a real one.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            trig_auto_q <= 1'b0;
        end else if (start_ok) begin
            trig_auto_q <= 1'b0;
        end else if (fire) begin
            trig_auto_q <= ~qual_trig;
        end
    end
`else
    logic unused_auto_timeout;

    assign unused_auto_timeout = ^auto_timeout;
    assign auto_hit            = 1'b0;
    assign trig_auto           = 1'b0;
`endif

    // Trigger synchronizer plus history flop.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= trig_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Acquisition FSM; depth is captured on state entry so later input changes are ignored.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            wr_en_q     <= 1'b0;
            acq_done_q  <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            acq_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt_q   <= '0;
                        depth_q <= pre_depth;
                        wr_en_q <= 1'b1;
                        state_q <= (pre_depth == '0) ? S_ARMED : S_PRE;
                    end
                end
                S_PRE: begin
                    if (acq_stop) begin
                        state_q <= S_IDLE;
                        wr_en_q <= 1'b0;
                    end else if (cnt_last) begin
                        state_q <= S_ARMED;
                    end else begin
                        cnt_q <= cnt_q + DEPTH_W'(1);
                    end
                end
                S_ARMED: begin
                    if (acq_stop) begin
                        state_q <= S_IDLE;
                        wr_en_q <= 1'b0;
                    end else if (fire) begin
                        trig_addr_q <= wr_addr_q;
                        cnt_q       <= '0;
                        depth_q     <= post_depth;
                        if (post_depth == '0) begin
                            state_q    <= S_DONE;
                            wr_en_q    <= 1'b0;
                            acq_done_q <= 1'b1;
                        end else begin
                            state_q <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (acq_stop) begin
                        state_q <= S_IDLE;
                        wr_en_q <= 1'b0;
                    end else if (cnt_last) begin
                        state_q    <= S_DONE;
                        wr_en_q    <= 1'b0;
                        acq_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DEPTH_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture address: cleared on start, advances on every write cycle, wraps silently.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
        end else if (start_ok) begin
            wr_addr_q <= '0;
        end else if (wr_en_q) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
    end

    // Trigger-after pulse: 4 cycles, retriggerable.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            aft_q     <= 1'b0;
            aft_cnt_q <= 2'd0;
        end else if (fire) begin
            aft_q     <= 1'b1;
            aft_cnt_q <= 2'd3;
        end else if (aft_q) begin
            if (aft_cnt_q == 2'd0) begin
                aft_q <= 1'b0;
            end else begin
                aft_cnt_q <= aft_cnt_q - 2'd1;
            end
        end
    end

    // Active-low holdoff reload: held low in reset, 4-cycle low pulse on start and on trigger.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            rld_n_q   <= 1'b0;
            rld_cnt_q <= 2'd0;
        end else if (start_ok || fire) begin
            rld_n_q   <= 1'b0;
            rld_cnt_q <= 2'd3;
        end else if (!rld_n_q) begin
            if (rld_cnt_q == 2'd0) begin
                rld_n_q <= 1'b1;
            end else begin
                rld_cnt_q <= rld_cnt_q - 2'd1;
            end
        end
    end

    assign trig_aft_pul        = aft_q;
    assign trig_holdoff_reload = rld_n_q;
    assign wr_en               = wr_en_q;
    assign wr_addr             = wr_addr_q;
    assign trig_addr           = trig_addr_q;
    assign acq_state           = state_q;
    assign acq_done            = acq_done_q;

endmodule

// File: tb/tb_trig_acq_ctrl.sv
// tb/tb_trig_acq_ctrl.sv - randomized self-checking bench for trig_acq_ctrl
module tb_trig_acq_ctrl;

    localparam int ADDR_W  = 4;
    localparam int DEPTH_W = 32;
    localparam int AMOD    = 1 << ADDR_W;
    localparam int NEVER   = 1 << 30;

    logic               clk_200M = 1'b0;
    logic               rst_n;
    logic               acq_start, acq_stop, trig_raw, force_trig, holdoff_busy;
    logic [DEPTH_W-1:0] pre_depth, post_depth;
    logic [31:0]        auto_timeout;
    logic               trig_aft_pul, trig_holdoff_reload, wr_en, acq_done, trig_auto;
    logic [ADDR_W-1:0]  wr_addr, trig_addr;
    logic [2:0]         acq_state;

    int n_checks = 0;
    int n_errors = 0;
    int exp_taddr = 0;

    trig_acq_ctrl #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) dut (
        .clk_200M            (clk_200M),
        .rst_n               (rst_n),
        .acq_start           (acq_start),
        .acq_stop            (acq_stop),
        .trig_raw            (trig_raw),
        .force_trig          (force_trig),
        .holdoff_busy        (holdoff_busy),
        .pre_depth           (pre_depth),
        .post_depth          (post_depth),
        .auto_timeout        (auto_timeout),
        .trig_aft_pul        (trig_aft_pul),
        .trig_holdoff_reload (trig_holdoff_reload),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .trig_addr           (trig_addr),
        .acq_state           (acq_state),
        .acq_done            (acq_done),
        .trig_auto           (trig_auto)
    );

    always #5 clk_200M = ~clk_200M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        acq_start    = 1'b0;
        acq_stop     = 1'b0;
        trig_raw     = 1'b0;
        force_trig   = 1'b0;
        holdoff_busy = 1'b0;
        pre_depth    = '0;
        post_depth   = '0;
        auto_timeout = '0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, acq_state, 0);
        chk({tag, "_hold"}, trig_holdoff_reload, 0);
        chk({tag, "_wren"}, wr_en, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_taddr"}, trig_addr, 0);
        chk({tag, "_aft"}, trig_aft_pul, 0);
        chk({tag, "_done"}, acq_done, 0);
        chk({tag, "_auto"}, trig_auto, 0);
    endtask

    // One acquisition. Cycle n is the interval after clock edge n; acq_start is driven in cycle 0.
    // kind: 0 force, 1 raw edge, 2 raw edge discarded by holdoff then a second edge,
    //       3 force with abort, 4 no trigger (auto timer).
    // Expected behaviour is derived from interval arithmetic on the acquisition timeline:
    // PRE = 1..p, ARMED = p+1..nt, POST = nt+1..nt+q, DONE = nt+q+1, write cycles 1..W.
    task automatic run_acq(input int p, input int q, input int kind);
        int  nt, s, m1, m2, w, wlast, done_c, ncyc, r_start, r_force;
        int  e_state, e_addr, e_taddr;
        bit  trig, auto_k, e_aft, e_auto;
        s      = NEVER;
        auto_k = 1'b0;
        w      = $urandom_range(0, 6);
        m1     = ((p > 0) ? p - 1 : 0) + int'($urandom_range(0, 4));
        m2     = m1 + 3 + int'($urandom_range(0, 3));
        case (kind)
            1:       nt = m1 + 2;
            2:       nt = m2 + 2;
            4: begin
`ifdef TRIG_AUTO_EN
                nt     = p + 100;
                auto_k = 1'b1;
`else
                nt = NEVER;
                s  = p + 130;
`endif
            end
            default: nt = p + 1 + w;
        endcase
        if (kind == 3) s = $urandom_range(1, nt + q);
        trig   = (nt < s);
        wlast  = trig ? ((s < nt + q) ? s : nt + q) : s;
        done_c = (trig && s > nt + q) ? nt + q + 1 : -1;
        ncyc   = (trig && nt + 4 > wlast + 1) ? nt + 8 : wlast + 5;
        r_start = $urandom_range(1, wlast);
        if (p > 0)                   r_force = $urandom_range(1, p);
        else if (q > 0 && trig)      r_force = $urandom_range(nt + 1, nt + q);
        else                         r_force = -1;

        for (int n = 0; n <= ncyc; n++) begin
            acq_start    = (n == 0) || (n == r_start);
            acq_stop     = (n == s);
            force_trig   = ((kind == 0 || kind == 3) && n == nt) || (n == r_force);
            trig_raw     = ((kind == 1 || kind == 2) && (n == m1 || n == m1 + 1)) ||
                           (kind == 2 && (n == m2 || n == m2 + 1));
            holdoff_busy = $urandom_range(0, 1);
            if (kind == 1 && n == m1 + 2) holdoff_busy = 1'b0;
            if (kind == 2 && n == m1 + 2) holdoff_busy = 1'b1;
            if (kind == 2 && n == m2 + 2) holdoff_busy = 1'b0;
            pre_depth    = (n == 0)  ? DEPTH_W'(p) : DEPTH_W'($urandom_range(0, 30));
            post_depth   = (n == nt) ? DEPTH_W'(q) : DEPTH_W'($urandom_range(0, 30));
            auto_timeout = (kind == 4) ? 32'd100 : 32'd0;
            @(negedge clk_200M);
            if (n >= 1) begin
                if (n <= wlast)       e_state = (n <= p) ? 1 : ((trig && n > nt) ? 3 : 2);
                else if (n == done_c) e_state = 4;
                else                  e_state = 0;
                e_aft   = trig && n > nt && n <= nt + 4;
                e_addr  = ((n < wlast + 1 ? n : wlast + 1) - 1) % AMOD;
                e_taddr = (trig && n > nt) ? (nt - 1) % AMOD : exp_taddr;
                e_auto  = auto_k && trig && n > nt;
                chk("state", acq_state, e_state);
                chk("wr_en", wr_en, (e_state >= 1 && e_state <= 3) ? 1 : 0);
                chk("acq_done", acq_done, (e_state == 4) ? 1 : 0);
                chk("wr_addr", wr_addr, e_addr);
                chk("trig_addr", trig_addr, e_taddr);
                chk("trig_aft_pul", trig_aft_pul, e_aft);
                chk("holdoff_reload", trig_holdoff_reload, (n <= 4 || e_aft) ? 0 : 1);
                chk("trig_auto", trig_auto, e_auto);
            end
            @(posedge clk_200M);
            #1;
        end
        if (trig) exp_taddr = (nt - 1) % AMOD;
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk_200M);
        @(negedge clk_200M);
        chk_reset_values("reset");
        @(posedge clk_200M);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_200M);
        #1;

        // start and stop together in IDLE: stop wins, no reload pulse
        acq_start = 1'b1;
        acq_stop  = 1'b1;
        pre_depth = 5;
        @(posedge clk_200M);
        #1;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_200M);
            chk("startstop_state", acq_state, 0);
            chk("startstop_hold", trig_holdoff_reload, 1);
            chk("startstop_wren", wr_en, 0);
        end
        @(posedge clk_200M);
        #1;

        run_acq(8, 16, 1);
        run_acq(0, 0, 0);
        run_acq(5, 6, 2);
        run_acq(20, 3, 0);
        run_acq(4, 10, 3);
        for (int i = 0; i < 30; i++) begin
            run_acq($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3));
        end
        run_acq($urandom_range(0, 5), $urandom_range(1, 8), 4);

        // asynchronous reset in the middle of POST with a trigger pulse in flight
        acq_start  = 1'b1;
        pre_depth  = 3;
        post_depth = 10;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk_200M);
            #1;
            acq_start  = 1'b0;
            force_trig = (n == 5);
        end
        @(negedge clk_200M);
        chk("midop_state", acq_state, 3);
        chk("midop_aft", trig_aft_pul, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        exp_taddr = 0;
        @(posedge clk_200M);
        #1;
        drive_idle();
        rst_n = 1'b1;
        repeat (2) @(posedge clk_200M);
        #1;
        run_acq(2, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
